// File: rtl/steel_mem_pkg.sv
// Shared constants and address decode for the Steel core memory responder.
package steel_mem_pkg;

  localparam int XLEN       = 32;
  localparam int WR_COUNT_W = 16;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic            in_range;
    logic [XLEN-3:0] word_idx;
  } addr_decode_t;

  // The offset subtraction wraps, so addresses below the base land far above
  // the window and fail the same single compare as addresses past the top.
  function automatic addr_decode_t decode_addr(input logic [XLEN-1:0] addr,
                                               input logic [XLEN-1:0] base,
                                               input int addr_bits);
    logic [XLEN-1:0] offset;
    addr_decode_t    r;
    offset     = addr - base;
    r.in_range = ((offset >> (addr_bits + 2)) == '0);
    r.word_idx = offset[XLEN-1:2];
    return r;
  endfunction

endpackage

// File: rtl/steel_mem_array.sv
// Word array with a byte-masked write-first data port and a read-first fetch
// port. Only the two output registers are reset; the array keeps its contents.
module steel_mem_array
  import steel_mem_pkg::*;
#(
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] d_idx,
  input  logic                 d_ok,
  input  logic                 wr_en,
  input  logic [3:0]           wr_mask,
  input  logic [XLEN-1:0]      wr_data,
  input  logic [ADDR_BITS-1:0] i_idx,
  input  logic                 i_ok,
  output logic [XLEN-1:0]      d_rdata,
  output logic [XLEN-1:0]      i_rdata
);

  logic [XLEN-1:0] mem [2**ADDR_BITS];
  logic [XLEN-1:0] d_merged;

  // Data-port view of the word as it will be after this edge's write.
  always_comb begin
    d_merged = mem[d_idx];
    for (int b = 0; b < 4; b++) begin
      if (wr_en && wr_mask[b]) d_merged[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  // Byte-lane array update; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem[d_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Output registers: data sees the merged word, fetch sees the pre-write word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_rdata <= '0;
      i_rdata <= NOP_INSTR;
    end else begin
      d_rdata <= d_ok ? d_merged : '0;
      i_rdata <= i_ok ? mem[i_idx] : NOP_INSTR;
    end
  end

endmodule

// File: rtl/steel_mem_responder.sv
// Memory responder for the Steel core: range checking, sticky error capture
// and a saturating write counter around the shared word array.
module steel_mem_responder
  import steel_mem_pkg::*;
#(
  parameter int              ADDR_BITS = 11,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [XLEN-1:0]       D_ADDR,
  input  logic [XLEN-1:0]       DATA_OUT,
  input  logic                  WR_REQ,
  input  logic [3:0]            WR_MASK,
  output logic [XLEN-1:0]       DATA_IN,
  input  logic [XLEN-1:0]       I_ADDR,
  output logic [XLEN-1:0]       INSTR,
  output logic                  ERR_VALID,
  output logic [XLEN-1:0]       ERR_ADDR,
  output logic [WR_COUNT_W-1:0] WR_COUNT
);

  addr_decode_t          d_dec;
  addr_decode_t          i_dec;
  logic                  wr_accept;
  logic                  err_valid;
  logic [XLEN-1:0]       err_addr;
  logic [WR_COUNT_W-1:0] wr_count;
  logic                  unused_idx_bits;

  assign d_dec = decode_addr(D_ADDR, BASE_ADDR, ADDR_BITS);
  assign i_dec = decode_addr(I_ADDR, BASE_ADDR, ADDR_BITS);

  // Upper index bits are always zero when the access is in range.
  assign unused_idx_bits = ^{d_dec.word_idx[XLEN-3:ADDR_BITS],
                             i_dec.word_idx[XLEN-3:ADDR_BITS]};

  assign wr_accept = WR_REQ && (WR_MASK != 4'h0) && d_dec.in_range && !RESET;

  steel_mem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk     (CLK),
    .rst     (RESET),
    .d_idx   (d_dec.word_idx[ADDR_BITS-1:0]),
    .d_ok    (d_dec.in_range),
    .wr_en   (wr_accept),
    .wr_mask (WR_MASK),
    .wr_data (DATA_OUT),
    .i_idx   (i_dec.word_idx[ADDR_BITS-1:0]),
    .i_ok    (i_dec.in_range),
    .d_rdata (DATA_IN),
    .i_rdata (INSTR)
  );

  // Capture the first bad address only; the data port wins a same-cycle tie.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else if (!err_valid) begin
      if (!d_dec.in_range) begin
        err_valid <= 1'b1;
        err_addr  <= D_ADDR;
      end else if (!i_dec.in_range) begin
        err_valid <= 1'b1;
        err_addr  <= I_ADDR;
      end
    end
  end

  // Count accepted writes, sticking at all-ones.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_count <= '0;
    end else if (wr_accept && (wr_count != '1)) begin
      wr_count <= wr_count + 1'b1;
    end
  end

  assign ERR_VALID = err_valid;
  assign ERR_ADDR  = err_addr;
  assign WR_COUNT  = wr_count;

endmodule

// File: tb/tb_steel_mem_responder.sv
// Scoreboard bench for steel_mem_responder: a word-array reference model
// predicts every registered output; a monitor compares each cycle.
module tb_steel_mem_responder;

  localparam int          WORDS = 2048;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] D_ADDR = '0;
  logic [31:0] DATA_OUT = '0;
  logic        WR_REQ = 1'b0;
  logic [3:0]  WR_MASK = '0;
  logic [31:0] DATA_IN;
  logic [31:0] I_ADDR = '0;
  logic [31:0] INSTR;
  logic        ERR_VALID;
  logic [31:0] ERR_ADDR;
  logic [15:0] WR_COUNT;

  steel_mem_responder dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .D_ADDR    (D_ADDR),
    .DATA_OUT  (DATA_OUT),
    .WR_REQ    (WR_REQ),
    .WR_MASK   (WR_MASK),
    .DATA_IN   (DATA_IN),
    .I_ADDR    (I_ADDR),
    .INSTR     (INSTR),
    .ERR_VALID (ERR_VALID),
    .ERR_ADDR  (ERR_ADDR),
    .WR_COUNT  (WR_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit [31:0] data;
    bit        chk_data;
    bit [31:0] instr;
    bit        chk_instr;
    bit        err;
    bit [31:0] err_addr;
    bit [15:0] cnt;
  } exp_t;

  exp_t      q[$];
  bit [31:0] mm [WORDS];
  bit        kn [WORDS];
  bit        m_err;
  bit [31:0] m_err_addr;
  int        m_cnt;
  int        n_cmp = 0;
  int        n_bad = 0;

  task automatic check(input string name, input bit [31:0] act, input bit [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_rng(input bit [31:0] a);
    return (a - BASE) < 32'(4 * WORDS);
  endfunction

  function automatic int widx(input bit [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Drive one cycle's inputs (called at a negedge), predict, wait a cycle.
  task automatic drive_cycle(input bit [31:0] da, input bit [31:0] wd, input bit wr,
                             input bit [3:0] mk, input bit [31:0] ia);
    exp_t e;
    int   dw;
    int   iw;
    D_ADDR = da; DATA_OUT = wd; WR_REQ = wr; WR_MASK = mk; I_ADDR = ia;
    if (in_rng(ia)) begin
      iw = widx(ia);
      e.instr = mm[iw];
      e.chk_instr = kn[iw];
    end else begin
      e.instr = NOP;
      e.chk_instr = 1'b1;
    end
    if (in_rng(da)) begin
      dw = widx(da);
      if (wr && mk != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (mk[b]) mm[dw][8*b +: 8] = wd[8*b +: 8];
        if (mk == 4'hF) kn[dw] = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end
      e.data = mm[dw];
      e.chk_data = kn[dw];
    end else begin
      e.data = 32'h0;
      e.chk_data = 1'b1;
    end
    if (!m_err) begin
      if (!in_rng(da)) begin
        m_err = 1'b1; m_err_addr = da;
      end else if (!in_rng(ia)) begin
        m_err = 1'b1; m_err_addr = ia;
      end
    end
    e.err = m_err;
    e.err_addr = m_err_addr;
    e.cnt = 16'(m_cnt);
    q.push_back(e);
    @(negedge CLK);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data_in"}, DATA_IN, 32'h0);
    check({tag, "_instr"}, INSTR, NOP);
    check({tag, "_err_valid"}, {31'h0, ERR_VALID}, 32'h0);
    check({tag, "_err_addr"}, ERR_ADDR, 32'h0);
    check({tag, "_wr_count"}, {16'h0, WR_COUNT}, 32'h0);
  endtask

  // Monitor: every cycle out of reset, pop the prediction and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (!RESET && q.size() > 0) begin
        e = q.pop_front();
        if (e.chk_data)  check("mon_data_in", DATA_IN, e.data);
        if (e.chk_instr) check("mon_instr", INSTR, e.instr);
        check("mon_err_valid", {31'h0, ERR_VALID}, {31'h0, e.err});
        check("mon_err_addr", ERR_ADDR, e.err_addr);
        check("mon_wr_count", {16'h0, WR_COUNT}, {16'h0, e.cnt});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [31:0] da;
    bit [31:0] ia;
    m_err = 1'b0; m_err_addr = '0; m_cnt = 0;

    repeat (3) @(negedge CLK);
    check_reset_values("reset");
    RESET = 1'b0;

    // Give a low window known contents (all zero).
    for (int w = 0; w < 128; w++) drive_cycle(32'(w * 4), 32'h0, 1'b1, 4'hF, 32'(w * 4));

    // Byte-masked store.
    drive_cycle(32'h100, 32'hAABB_CCDD, 1'b1, 4'hF, 32'h0);
    drive_cycle(32'h100, 32'h1122_3344, 1'b1, 4'b0101, 32'h0);
    drive_cycle(32'h100, 32'h0, 1'b0, 4'h0, 32'h0);
    check("mask_data", DATA_IN, 32'hAA22_CC44);
    check("mask_count", {16'h0, WR_COUNT}, 32'd130);

    // Same-word collision between write, data read and fetch.
    drive_cycle(32'h40, 32'hDEAD_BEEF, 1'b1, 4'hF, 32'h40);
    check("coll_data", DATA_IN, 32'hDEAD_BEEF);
    check("coll_instr_old", INSTR, 32'h0);
    drive_cycle(32'h40, 32'h0, 1'b0, 4'h0, 32'h40);
    check("coll_instr_new", INSTR, 32'hDEAD_BEEF);

    // Random in-range traffic, low address bits scrambled.
    for (int n = 0; n < 300; n++) begin
      da = {23'h0, 7'($urandom_range(0, 127)), 2'($urandom)};
      ia = {23'h0, 7'($urandom_range(0, 127)), 2'($urandom)};
      drive_cycle(da, $urandom, 1'($urandom), 4'($urandom), ia);
    end

    // Out-of-range store, then a later bad fetch.
    drive_cycle(32'h2000, 32'h1234_5678, 1'b1, 4'hF, 32'h0);
    check("oor_data", DATA_IN, 32'h0);
    check("oor_err_valid", {31'h0, ERR_VALID}, 32'h1);
    check("oor_err_addr", ERR_ADDR, 32'h2000);
    drive_cycle(32'h0, 32'h0, 1'b0, 4'h0, 32'h3000);
    check("oor_keep_addr", ERR_ADDR, 32'h2000);
    check("oor_instr", INSTR, NOP);

    // Reset between edges with a store pending.
    drive_cycle(32'h80, 32'hCAFE_F00D, 1'b1, 4'hF, 32'h0);
    D_ADDR = 32'h80; DATA_OUT = 32'h5555_5555; WR_REQ = 1'b1; WR_MASK = 4'hF; I_ADDR = 32'h80;
    #2 RESET = 1'b1;
    #1 check_reset_values("midrst");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    WR_REQ = 1'b0; WR_MASK = 4'h0;
    @(negedge CLK);
    RESET = 1'b0;
    m_err = 1'b0; m_err_addr = '0; m_cnt = 0;
    drive_cycle(32'h80, 32'h0, 1'b0, 4'h0, 32'h80);
    check("midrst_data", DATA_IN, 32'hCAFE_F00D);
    check("midrst_instr", INSTR, 32'hCAFE_F00D);
    check("midrst_count", {16'h0, WR_COUNT}, 32'h0);

    // Both ports out of range together.
    drive_cycle(32'h4000, 32'h0, 1'b0, 4'h0, 32'h5000);
    check("dual_err_addr", ERR_ADDR, 32'h4000);
    check("dual_instr", INSTR, NOP);

    // Random mixed traffic including out-of-range addresses.
    for (int n = 0; n < 400; n++) begin
      da = ($urandom_range(0, 9) < 8) ? {23'h0, 7'($urandom_range(0, 127)), 2'($urandom)} : $urandom;
      ia = ($urandom_range(0, 9) < 8) ? {23'h0, 7'($urandom_range(0, 127)), 2'($urandom)} : $urandom;
      drive_cycle(da, $urandom, 1'($urandom), 4'($urandom), ia);
    end

    @(negedge CLK);
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
